// File: rtl/level_loader.sv
// Purpose: streams a stage's wall/destination/box/player bit-planes from a registered ROM into packed grid registers; optional validation via LEVEL_CHECK_EN.
// Latency: done pulses 3+4*GRID_H cycles after an accepted load_req (35 for an 8x8 grid); a rejected stage index gets done the next cycle.
// Backpressure: none; load_req is ignored while busy (not queued), and the consumer picks the planes up on the done pulse.
module level_loader #(
    parameter int GRID_W   = 8,
    parameter int GRID_H   = 8,
    parameter int N_STAGES = 4,
    parameter int STAGE_W  = 2,
    parameter int X_W      = 3,
    parameter int Y_W      = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   load_req,
    input  logic [STAGE_W-1:0]                     stage,
    output logic [STAGE_W+2+$clog2(GRID_H)-1:0]    rom_addr,
    input  logic [GRID_W-1:0]                      rom_data,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   load_ok,
    output logic [GRID_W*GRID_H-1:0]               wall,
    output logic [GRID_W*GRID_H-1:0]               destination,
    output logic [GRID_W*GRID_H-1:0]               box,
    output logic [X_W-1:0]                         player_x,
    output logic [Y_W-1:0]                         player_y
);

    localparam int ROW_W = $clog2(GRID_H);
    localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(GRID_H - 1);
    localparam logic [STAGE_W:0]   STAGE_LIM = (STAGE_W + 1)'(N_STAGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_CHECK,
        S_FIN
    } state_t;

    state_t               state;
    logic [STAGE_W-1:0]   stage_q;
    logic [1:0]           plane_cnt;
    logic [ROW_W-1:0]     row_cnt;

    // Address of the read whose data is on rom_data this cycle.
    logic                 cap_vld;
    logic [1:0]           cap_plane;
    logic [ROW_W-1:0]     cap_row;

    logic                 player_found;
    logic                 accept;
    logic                 stage_in_range;
    logic                 level_ok;
    logic                 row_hit;
    logic [X_W-1:0]       first_col;

    assign rom_addr       = {stage_q, plane_cnt, row_cnt};
    assign stage_in_range = ({1'b0, stage} < STAGE_LIM);
    assign accept         = (state == S_IDLE) && load_req && stage_in_range;

    // Leftmost set column of the incoming row (column 0 is the MSB).
    always_comb begin
        row_hit   = |rom_data;
        first_col = '0;
        for (int c = GRID_W - 1; c >= 0; c--) begin
            if (rom_data[GRID_W-1-c]) first_col = X_W'(c);
        end
    end

`ifdef LEVEL_CHECK_EN
    localparam int CNT_W = $clog2(GRID_W * GRID_H + 1);

    logic [CNT_W-1:0]  box_cnt;
    logic [CNT_W-1:0]  dst_cnt;
    logic [CNT_W-1:0]  ply_cnt;
    logic              overlap;
    logic [GRID_W-1:0] wall_row;
    logic [GRID_W-1:0] box_row;

    function automatic logic [CNT_W-1:0] popcnt(input logic [GRID_W-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int i = 0; i < GRID_W; i++) s = s + CNT_W'(v[i]);
        return s;
    endfunction

    // Wall and box rows already loaded for the row being captured; planes arrive
    // in order wall, destination, box, player so overlaps are checked on the fly.
    always_comb begin
        wall_row = '0;
        box_row  = '0;
        for (int r = 0; r < GRID_H; r++) begin
            if (cap_row == ROW_W'(r)) begin
                wall_row = wall[(GRID_H-1-r)*GRID_W +: GRID_W];
                box_row  = box[(GRID_H-1-r)*GRID_W +: GRID_W];
            end
        end
    end

    assign level_ok = (box_cnt == dst_cnt) && (box_cnt != '0) &&
                      (ply_cnt == CNT_W'(1)) && !overlap;
`else
    assign level_ok = 1'b1;
`endif

    // Control FSM: address sequencing, capture pipeline, busy/done/load_ok.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stage_q   <= '0;
            plane_cnt <= '0;
            row_cnt   <= '0;
            cap_vld   <= 1'b0;
            cap_plane <= '0;
            cap_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_ok   <= 1'b0;
        end else begin
            done    <= 1'b0;
            cap_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_req) begin
                        busy    <= 1'b1;
                        load_ok <= 1'b0;
                        if (stage_in_range) begin
                            stage_q   <= stage;
                            plane_cnt <= '0;
                            row_cnt   <= '0;
                            state     <= S_FETCH;
                        end else begin
                            // Out-of-range stage: no ROM traffic, report failure.
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_FETCH: begin
                    cap_vld   <= 1'b1;
                    cap_plane <= plane_cnt;
                    cap_row   <= row_cnt;
                    if (row_cnt == ROW_LAST) begin
                        if (plane_cnt == 2'd3) begin
                            state <= S_DRAIN;
                        end else begin
                            row_cnt   <= '0;
                            plane_cnt <= plane_cnt + 2'd1;
                        end
                    end else begin
                        row_cnt <= row_cnt + ROW_W'(1);
                    end
                end
                S_DRAIN: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    load_ok <= level_ok;
                    done    <= 1'b1;
                    state   <= S_FIN;
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Row capture into the plane registers, player position and level statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wall         <= '0;
            destination  <= '0;
            box          <= '0;
            player_x     <= '0;
            player_y     <= '0;
            player_found <= 1'b0;
`ifdef LEVEL_CHECK_EN
            box_cnt      <= '0;
            dst_cnt      <= '0;
            ply_cnt      <= '0;
            overlap      <= 1'b0;
`endif
        end else if (accept) begin
            player_found <= 1'b0;
`ifdef LEVEL_CHECK_EN
            box_cnt      <= '0;
            dst_cnt      <= '0;
            ply_cnt      <= '0;
            overlap      <= 1'b0;
`endif
        end else if (cap_vld) begin
            for (int r = 0; r < GRID_H; r++) begin
                if (cap_row == ROW_W'(r)) begin
                    case (cap_plane)
                        2'd0:    wall[(GRID_H-1-r)*GRID_W +: GRID_W]        <= rom_data;
                        2'd1:    destination[(GRID_H-1-r)*GRID_W +: GRID_W] <= rom_data;
                        2'd2:    box[(GRID_H-1-r)*GRID_W +: GRID_W]         <= rom_data;
                        default: ;
                    endcase
                end
            end
            // An empty player plane leaves the previous position in place.
            if (cap_plane == 2'd3 && !player_found && row_hit) begin
                player_found <= 1'b1;
                player_x     <= first_col;
                player_y     <= Y_W'(cap_row);
            end
`ifdef LEVEL_CHECK_EN
            case (cap_plane)
                2'd1: begin
                    dst_cnt <= dst_cnt + popcnt(rom_data);
                    if (|(rom_data & wall_row)) overlap <= 1'b1;
                end
                2'd2: begin
                    box_cnt <= box_cnt + popcnt(rom_data);
                    if (|(rom_data & wall_row)) overlap <= 1'b1;
                end
                2'd3: begin
                    ply_cnt <= ply_cnt + popcnt(rom_data);
                    if (|(rom_data & (wall_row | box_row))) overlap <= 1'b1;
                end
                default: ;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_level_loader.sv
module tb_level_loader;

`ifdef LEVEL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;

    // 8x8 grid, three stages
    logic         load_req;
    logic [1:0]   stage;
    logic [6:0]   rom_addr;
    logic [7:0]   rom_data;
    logic         busy, done, load_ok;
    logic [63:0]  wall, destination, box;
    logic [2:0]   player_x, player_y;

    // 12x10 grid
    logic         load_req2;
    logic [1:0]   stage2;
    logic [7:0]   rom_addr2;
    logic [11:0]  rom_data2;
    logic         busy2, done2, load_ok2;
    logic [119:0] wall2, destination2, box2;
    logic [3:0]   player_x2, player_y2;

    level_loader #(.GRID_W(8), .GRID_H(8), .N_STAGES(3), .STAGE_W(2), .X_W(3), .Y_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .load_req(load_req), .stage(stage),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
        .load_ok(load_ok), .wall(wall), .destination(destination), .box(box),
        .player_x(player_x), .player_y(player_y)
    );

    level_loader #(.GRID_W(12), .GRID_H(10), .N_STAGES(4), .STAGE_W(2), .X_W(4), .Y_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .load_req(load_req2), .stage(stage2),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .busy(busy2), .done(done2),
        .load_ok(load_ok2), .wall(wall2), .destination(destination2), .box(box2),
        .player_x(player_x2), .player_y(player_y2)
    );

    // Registered ROM models
    logic [7:0]  rom1 [128];
    logic [11:0] rom2 [256];
    always @(posedge clk) begin
        rom_data  <= rom1[rom_addr];
        rom_data2 <= rom2[rom_addr2];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_plane(input int s, input int p, input logic [63:0] v);
        for (int r = 0; r < 8; r++) rom1[s*32 + p*8 + r] = v[(7-r)*8 +: 8];
    endtask

    // Ticks until done (counting from the accept cycle), bounded.
    task automatic wait_done(input int start, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = start;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            lat++;
            if (done) seen = 1'b1;
        end
    endtask

    localparam logic [63:0] S0_WALL = 64'h3828_2fe1_87f4_141c;
    localparam logic [63:0] S0_DST  = 64'h0010_0002_4000_0800;
    localparam logic [63:0] S0_BOX  = 64'h0010_001A_5008_0800;
    localparam logic [63:0] S0_PLY  = 64'h0000_0000_0800_0000;
    localparam logic [63:0] S1_WALL = 64'h0;
    localparam logic [63:0] S1_DST  = 64'hF000_0000_0000_0000;
    localparam logic [63:0] S1_BOX  = 64'h00F8_0000_0000_0000;
    localparam logic [63:0] S1_PLY  = 64'h0000_0000_0000_0001;
    localparam logic [63:0] S2_WALL = 64'h0000_0000_0000_FF00;
    localparam logic [63:0] S2_DST  = 64'hF000_0000_0000_0000;
    localparam logic [63:0] S2_BOX  = 64'h00F0_0000_0000_0000;
    localparam logic [63:0] S2_PLY  = 64'h0000_0000_0020_0000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           lat;
        logic [127:0] seen_addr;
        bit           done_seen;
        logic [119:0] exp_wall2;

        rst_n     = 1'b0;
        load_req  = 1'b0;
        stage     = 2'd0;
        load_req2 = 1'b0;
        stage2    = 2'd0;
        for (int i = 0; i < 128; i++) rom1[i] = 8'h00;
        for (int i = 0; i < 256; i++) rom2[i] = 12'h000;
        put_plane(0, 0, S0_WALL); put_plane(0, 1, S0_DST); put_plane(0, 2, S0_BOX); put_plane(0, 3, S0_PLY);
        put_plane(1, 0, S1_WALL); put_plane(1, 1, S1_DST); put_plane(1, 2, S1_BOX); put_plane(1, 3, S1_PLY);
        put_plane(2, 0, S2_WALL); put_plane(2, 1, S2_DST); put_plane(2, 2, S2_BOX); put_plane(2, 3, S2_PLY);
        rom2[{2'd0, 2'd0, 4'd0}] = 12'hABC;
        rom2[{2'd0, 2'd3, 4'd9}] = 12'h001;
        exp_wall2 = '0;
        exp_wall2[119:108] = 12'hABC;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_load_ok", load_ok, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_wall", wall, 0);
        chk("rst_dst", destination, 0);
        chk("rst_box", box, 0);
        chk("rst_px", player_x, 0);
        chk("rst_py", player_y, 0);
        rst_n = 1'b1;
        tick(); tick();

        // Stage 0: address sequence, latency, planes, player
        stage    = 2'd0;
        load_req = 1'b1;
        lat = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 100 && !done_seen; k++) begin
            tick();
            lat++;
            if (lat == 1) load_req = 1'b0;
            if (lat <= 32) chk("s0_addr_seq", rom_addr, lat - 1);
            if (done) done_seen = 1'b1;
        end
        chk("s0_latency", lat, 35);
        chk("s0_wall", wall, S0_WALL);
        chk("s0_dst", destination, S0_DST);
        chk("s0_box", box, S0_BOX);
        chk("s0_px", player_x, 4);
        chk("s0_py", player_y, 4);
        chk("s0_load_ok", load_ok, CHK_EN ? 0 : 1);

        // Rejected stage index
        tick();
        stage    = 2'd3;
        load_req = 1'b1;
        tick();
        chk("rej_done", done, 1);
        chk("rej_load_ok", load_ok, 0);
        chk("rej_busy", busy, 1);
        chk("rej_rom_addr", rom_addr, 7'h1F);
        chk("rej_wall", wall, S0_WALL);
        chk("rej_box", box, S0_BOX);
        chk("rej_px", player_x, 4);
        load_req = 1'b0;
        tick();
        chk("rej_idle_busy", busy, 0);
        chk("rej_idle_done", done, 0);

        // load_req held high through stage 1, then back-to-back stage 2
        stage     = 2'd1;
        load_req  = 1'b1;
        seen_addr = '0;
        lat = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 100 && !done_seen; k++) begin
            tick();
            lat++;
            if (lat == 1) chk("s1_first_addr", rom_addr, 7'h20);
            if (busy) seen_addr[rom_addr] = 1'b1;
            if (done) done_seen = 1'b1;
        end
        stage = 2'd2;
        chk("s1_latency", lat, 35);
        chk("s1_distinct_addr", $countones(seen_addr), 32);
        chk("s1_dst", destination, S1_DST);
        chk("s1_box", box, S1_BOX);
        chk("s1_wall", wall, S1_WALL);
        chk("s1_px", player_x, 7);
        chk("s1_py", player_y, 7);
        chk("s1_load_ok", load_ok, CHK_EN ? 0 : 1);
        tick();
        chk("b2b_idle", busy, 0);
        tick();
        chk("b2b_accept_busy", busy, 1);
        chk("b2b_accept_addr", rom_addr, 7'h40);
        load_req = 1'b0;
        wait_done(1, lat);
        chk("s2_latency", lat, 35);
        chk("s2_wall", wall, S2_WALL);
        chk("s2_dst", destination, S2_DST);
        chk("s2_box", box, S2_BOX);
        chk("s2_px", player_x, 2);
        chk("s2_py", player_y, 5);
        chk("s2_load_ok", load_ok, 1);

        // Reset in the middle of a load
        tick();
        stage    = 2'd0;
        load_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            load_req = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_load_ok", load_ok, 0);
        chk("mid_rst_rom_addr", rom_addr, 0);
        chk("mid_rst_wall", wall, 0);
        chk("mid_rst_dst", destination, 0);
        chk("mid_rst_box", box, 0);
        chk("mid_rst_px", player_x, 0);
        chk("mid_rst_py", player_y, 0);
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (k == 2) rst_n = 1'b1;
            if (done) done_seen = 1'b1;
        end
        chk("mid_rst_no_done", done_seen, 0);
        stage    = 2'd2;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_done(1, lat);
        chk("post_rst_latency", lat, 35);
        chk("post_rst_wall", wall, S2_WALL);
        chk("post_rst_box", box, S2_BOX);
        chk("post_rst_px", player_x, 2);
        chk("post_rst_py", player_y, 5);
        chk("post_rst_load_ok", load_ok, 1);

        // 12x10 grid: player at the last row and column
        stage2    = 2'd0;
        load_req2 = 1'b1;
        lat = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 100 && !done_seen; k++) begin
            tick();
            lat++;
            load_req2 = 1'b0;
            if (done2) done_seen = 1'b1;
        end
        chk("g12_latency", lat, 43);
        chk("g12_px", player_x2, 11);
        chk("g12_py", player_y2, 9);
        chk("g12_wall", wall2, exp_wall2);
        chk("g12_load_ok", load_ok2, CHK_EN ? 0 : 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
